alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the CPU datapath. It executes the single-cycle R-/I-type operations with one-cycle registered latency. It also adds iterative signed/unsigned multiply and unsigned divide, producing a double-width result on result_o and hi_o. Operations are issued through a start/ready handshake and completed with a valid_o pulse, so the control unit can stall the pipeline while a long operation runs.

---
 rtl/alu_if.sv | 24 ++
 rtl/alu_mc.sv | 142 ++++++++++++++
 tb/tb_alu_mc.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// alu_if: issue/complete handshake and operand/result bus of the multi-cycle ALU
interface alu_if #(parameter int WIDTH = 32);
  localparam int SHW = $clog2(WIDTH);
  logic             start_i;
  logic             ready_o;
  logic             busy_o;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [3:0]       ctrl_i;
  logic [SHW-1:0]   shamt_i;
  logic [WIDTH-1:0] result_o;
  logic [WIDTH-1:0] hi_o;
  logic             zero_o;
  logic             valid_o;
  logic             err_o;
  modport master (
    output start_i, src1_i, src2_i, ctrl_i, shamt_i,
    input  ready_o, busy_o, result_o, hi_o, zero_o, valid_o, err_o
  );
  modport slave (
    input  start_i, src1_i, src2_i, ctrl_i, shamt_i,
    output ready_o, busy_o, result_o, hi_o, zero_o, valid_o, err_o
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU; single-cycle ops, shift-add MULT/MULTU, restoring DIVU.
// Define ALU_DIV_EN to build the divider; otherwise code 15 completes with err_o.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input logic clk_i,
  input logic rst_i,
  alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod, mul_step, mul_fin;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mcand, abs1, abs2, alu_res, result, hi;
  logic               neg, valid, err, accept, is_mul, div_go, last;
  assign accept = bus.start_i && state == IDLE;
  assign is_mul = bus.ctrl_i == 4'd13 || bus.ctrl_i == 4'd14;
  assign last   = cnt == CW'(1);
  assign abs1 = (bus.ctrl_i == 4'd13 && bus.src1_i[WIDTH-1]) ? -bus.src1_i : bus.src1_i;
  assign abs2 = (bus.ctrl_i == 4'd13 && bus.src2_i[WIDTH-1]) ? -bus.src2_i : bus.src2_i;
  // product register holds {accumulator, remaining multiplier bits}
  assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign mul_step = {mul_sum, prod[WIDTH-1:1]};
  assign mul_fin  = neg ? -mul_step : mul_step;
`ifdef ALU_DIV_EN
  logic [WIDTH-1:0]   dvs;
  logic [2*WIDTH:0]   div_sh;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] div_step;
  assign div_go   = bus.ctrl_i == 4'd15 && bus.src2_i != '0;
  // {remainder, dividend/quotient} shifted left; keep the subtraction if it did not borrow
  assign div_sh   = {prod, 1'b0};
  assign trial    = div_sh[2*WIDTH:WIDTH] - {1'b0, dvs};
  assign div_step = trial[WIDTH] ? div_sh[2*WIDTH-1:0] : {trial[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
`else
  assign div_go = 1'b0;
`endif
  always_comb begin
    alu_res = '0;
    case (bus.ctrl_i)
      4'd0:        alu_res = bus.src1_i & bus.src2_i;
      4'd1:        alu_res = bus.src1_i | bus.src2_i;
      4'd2, 4'd9:  alu_res = bus.src1_i + bus.src2_i;
      4'd3:        alu_res = bus.src1_i - bus.src2_i;
      4'd4:        alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.src1_i) < $signed(bus.src2_i)};
      4'd5:        alu_res = $signed(bus.src2_i) >>> bus.shamt_i;
      4'd6:        alu_res = $signed(bus.src2_i) >>> bus.src1_i[SHW-1:0];
      4'd7:        alu_res = {{(WIDTH-1){1'b0}}, bus.src1_i != bus.src2_i};
      4'd8:        alu_res = {{(WIDTH-1){1'b0}}, bus.src1_i == bus.src2_i};
      4'd10:       alu_res = {{(WIDTH-1){1'b0}}, bus.src1_i < bus.src2_i};
      4'd11:       alu_res = bus.src1_i | {{(WIDTH/2){1'b0}}, bus.src2_i[WIDTH/2-1:0]};
      4'd12:       alu_res = {bus.src2_i[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default:     alu_res = '0;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (accept && is_mul ? MUL : accept && div_go ? DIV : IDLE)
             : last ? IDLE : state;
  end
  always_comb begin
    bus.ready_o  = state == IDLE;
    bus.busy_o   = state != IDLE;
    bus.result_o = result;
    bus.hi_o     = hi;
    bus.zero_o   = result == '0;
    bus.valid_o  = valid;
    bus.err_o    = err;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      result <= '0;
      hi     <= '0;
      err    <= 1'b0;
      valid  <= 1'b0;
      prod   <= '0;
      mcand  <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
`ifdef ALU_DIV_EN
      dvs    <= '0;
`endif
    end else begin
      valid <= 1'b0;
      if (accept) begin
        if (is_mul) begin
          mcand <= abs1;
          prod  <= {{WIDTH{1'b0}}, abs2};
          neg   <= bus.ctrl_i == 4'd13 && (bus.src1_i[WIDTH-1] ^ bus.src2_i[WIDTH-1]);
          cnt   <= CW'(WIDTH);
        end else if (bus.ctrl_i == 4'd15) begin
`ifdef ALU_DIV_EN
          if (div_go) begin
            prod <= {{WIDTH{1'b0}}, bus.src1_i};
            dvs  <= bus.src2_i;
            cnt  <= CW'(WIDTH);
          end else begin
            result <= '1;
            hi     <= bus.src1_i;
            err    <= 1'b1;
            valid  <= 1'b1;
          end
`else
          result <= '0;
          hi     <= '0;
          err    <= 1'b1;
          valid  <= 1'b1;
`endif
        end else begin
          result <= alu_res;
          hi     <= '0;
          err    <= 1'b0;
          valid  <= 1'b1;
        end
      end else if (state == MUL) begin
        prod <= mul_step;
        cnt  <= cnt - CW'(1);
        if (last) begin
          {hi, result} <= mul_fin;
          err          <= 1'b0;
          valid        <= 1'b1;
        end
      end
`ifdef ALU_DIV_EN
      else if (state == DIV) begin
        prod <= div_step;
        cnt  <= cnt - CW'(1);
        if (last) begin
          result <= div_step[WIDTH-1:0];
          hi     <= div_step[2*WIDTH-1:WIDTH];
          err    <= 1'b0;
          valid  <= 1'b1;
        end
      end
`endif
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc (WIDTH=32)
module tb_alu_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int lat;
  int nvalid;
  alu_if #(.WIDTH(32)) bus ();
  alu_mc #(.WIDTH(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2, input logic [4:0] sh);
    bus.start_i = 1'b1;
    bus.ctrl_i  = op;
    bus.src1_i  = s1;
    bus.src2_i  = s2;
    bus.shamt_i = sh;
  endtask
  task automatic wait_valid(inout int n);
    while (!bus.valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [4:0] sh, input logic [31:0] er, input logic [31:0] eh, input logic ee, input int el);
    drive(op, s1, s2, sh);
    @(negedge clk);
    bus.start_i = 1'b0;
    lat = 1;
    wait_valid(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(el));
    chk({tag, "_res"}, 64'(bus.result_o), 64'(er));
    chk({tag, "_hi"}, 64'(bus.hi_o), 64'(eh));
    chk({tag, "_err"}, 64'(bus.err_o), 64'(ee));
    chk({tag, "_zero"}, 64'(bus.zero_o), 64'(er == 32'd0));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(bus.valid_o), 64'd0);
  endtask
  initial begin
    bus.start_i = 1'b0;
    bus.ctrl_i  = '0;
    bus.src1_i  = '0;
    bus.src2_i  = '0;
    bus.shamt_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_res", 64'(bus.result_o), 64'd0);
    chk("rst_hi", 64'(bus.hi_o), 64'd0);
    chk("rst_zero", 64'(bus.zero_o), 64'd1);
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_err", 64'(bus.err_o), 64'd0);
    chk("rst_ready", 64'(bus.ready_o), 64'd1);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    do_op("add", 4'd2, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 32'h0, 1'b0, 1);
    drive(4'd3, 32'd5, 32'd5, 5'd0);
    @(negedge clk);
    chk("b2b_sub_valid", 64'(bus.valid_o), 64'd1);
    chk("b2b_sub_res", 64'(bus.result_o), 64'd0);
    chk("b2b_sub_zero", 64'(bus.zero_o), 64'd1);
    drive(4'd4, 32'hFFFF_FFFF, 32'd1, 5'd0);
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("b2b_slt_valid", 64'(bus.valid_o), 64'd1);
    chk("b2b_slt_res", 64'(bus.result_o), 64'd1);
    chk("b2b_slt_zero", 64'(bus.zero_o), 64'd0);
    @(negedge clk);
    chk("b2b_pulse", 64'(bus.valid_o), 64'd0);
    do_op("and", 4'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 32'h00F0_1200, 32'h0, 1'b0, 1);
    do_op("or", 4'd1, 32'hF000_0001, 32'h0000_0F00, 5'd0, 32'hF000_0F01, 32'h0, 1'b0, 1);
    do_op("beq_eq", 4'd7, 32'd5, 32'd5, 5'd0, 32'd0, 32'h0, 1'b0, 1);
    do_op("beq_ne", 4'd7, 32'd5, 32'd6, 5'd0, 32'd1, 32'h0, 1'b0, 1);
    do_op("bne_eq", 4'd8, 32'd5, 32'd5, 5'd0, 32'd1, 32'h0, 1'b0, 1);
    do_op("bne_ne", 4'd8, 32'd5, 32'd6, 5'd0, 32'd0, 32'h0, 1'b0, 1);
    do_op("addi_wrap", 4'd9, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'd1, 32'h0, 1'b0, 1);
    do_op("sltiu", 4'd10, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'd1, 32'h0, 1'b0, 1);
    do_op("slt_signed", 4'd4, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'd0, 32'h0, 1'b0, 1);
    do_op("lui", 4'd12, 32'h0, 32'hABCD_1234, 5'd0, 32'h1234_0000, 32'h0, 1'b0, 1);
    do_op("sra", 4'd5, 32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000, 32'h0, 1'b0, 1);
    do_op("srav", 4'd6, 32'hFFFF_FF08, 32'h8000_0000, 5'd0, 32'hFF80_0000, 32'h0, 1'b0, 1);
    drive(4'd13, 32'hFFFF_FFFE, 32'd3, 5'd0);
    @(negedge clk);
    chk("mult_busy", 64'(bus.busy_o), 64'd1);
    chk("mult_ready", 64'(bus.ready_o), 64'd0);
    drive(4'd2, 32'd1, 32'd1, 5'd0);
    @(negedge clk);
    bus.start_i = 1'b0;
    lat = 2;
    wait_valid(lat);
    chk("mult_lat", 64'(lat), 64'd33);
    chk("mult_hi", 64'(bus.hi_o), 64'hFFFF_FFFF);
    chk("mult_res", 64'(bus.result_o), 64'hFFFF_FFFA);
    chk("mult_ready_valid", 64'(bus.ready_o), 64'd1);
    @(negedge clk);
    chk("mult_pulse", 64'(bus.valid_o), 64'd0);
    chk("mult_ignored", 64'(bus.result_o), 64'hFFFF_FFFA);
    do_op("mult_pos", 4'd13, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 5'd0, 32'd21, 32'h0, 1'b0, 33);
    do_op("multu", 4'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 33);
`ifdef ALU_DIV_EN
    do_op("divu", 4'd15, 32'd100, 32'd7, 5'd0, 32'd14, 32'd2, 1'b0, 33);
    do_op("divu_big", 4'd15, 32'hFFFF_FFFF, 32'h8000_0000, 5'd0, 32'd1, 32'h7FFF_FFFF, 1'b0, 33);
    do_op("divu_zero", 4'd15, 32'd9, 32'd0, 5'd0, 32'hFFFF_FFFF, 32'd9, 1'b1, 1);
`else
    do_op("divu_off", 4'd15, 32'd100, 32'd7, 5'd0, 32'd0, 32'd0, 1'b1, 1);
`endif
    do_op("pre_rst", 4'd2, 32'd3, 32'd4, 5'd0, 32'd7, 32'd0, 1'b0, 1);
    drive(4'd14, 32'd5, 32'd7, 5'd0);
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_res", 64'(bus.result_o), 64'd0);
    chk("mrst_hi", 64'(bus.hi_o), 64'd0);
    chk("mrst_zero", 64'(bus.zero_o), 64'd1);
    chk("mrst_valid", 64'(bus.valid_o), 64'd0);
    chk("mrst_err", 64'(bus.err_o), 64'd0);
    chk("mrst_ready", 64'(bus.ready_o), 64'd1);
    chk("mrst_busy", 64'(bus.busy_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.valid_o) nvalid++;
    end
    chk("mrst_no_valid", 64'(nvalid), 64'd0);
    do_op("ori", 4'd11, 32'h0000_00F0, 32'hFFFF_1234, 5'd0, 32'h0000_12F4, 32'h0, 1'b0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
